seq_mult_n: RTL

Parametrised sequential shift-add multiplier producing a full 2×WIDTH product from two WIDTH-bit operands, selectable per operation as signed or unsigned. One partial-product bit is retired per cycle. Valid/ready handshakes on both the operand side and the result side let it sit between a register-file read stage and a writeback stage without external sequencing. It supersedes the fixed 16-bit serial multiplier in the arithmetic library.

---
 rtl/seq_mult_pkg.sv | 20 ++
 rtl/seq_mult_step.sv | 21 ++
 rtl/seq_mult_n.sv | 109 ++++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

  // Callers zero-extend into 64 bits and truncate the result back; the low
  // bits of a wide negation equal the narrow negation.
  function automatic logic [63:0] neg2w(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

endpackage

// File: rtl/seq_mult_step.sv
// One shift-add iteration: conditionally add |a| into hi, then shift {sum, lo} right.
module seq_mult_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] a_mag_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // Carry out of the add lands in the top bit of hi after the shift.
  logic [WIDTH:0] sum;

  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, a_mag_i} : '0);
    hi_o = sum[WIDTH:1];
    lo_o = {sum[0], lo_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_mult_n.sv
// Sequential WIDTH x WIDTH -> 2*WIDTH multiplier, signed via sign/magnitude,
// one partial-product bit per cycle, valid/ready on both sides.
module seq_mult_n
  import seq_mult_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] p_o,
  output logic               busy_o
);

  localparam int CW = cnt_w(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, a_mag_q, a_mag_d;
  logic             sgn_q, sgn_d;
  logic [PW-1:0]    p_q, p_d;

  logic [WIDTH-1:0] hi_nx, lo_nx;
  logic             signed_op, a_neg, b_neg;

  seq_mult_step #(.WIDTH(WIDTH)) u_step (
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .a_mag_i (a_mag_q),
    .hi_o    (hi_nx),
    .lo_o    (lo_nx)
  );

  always_comb begin
    signed_op = signed_i & SIGNED_EN;
    a_neg     = signed_op & a_i[WIDTH-1];
    b_neg     = signed_op & b_i[WIDTH-1];

    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_mag_d = a_mag_q;
    sgn_d   = sgn_q;
    p_d     = p_q;

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = RUN;
          sgn_d   = a_neg ^ b_neg;
          // -2^(W-1) negates to itself, which is the correct unsigned magnitude.
          a_mag_d = a_neg ? WIDTH'(neg2w(64'(a_i))) : a_i;
          lo_d    = b_neg ? WIDTH'(neg2w(64'(b_i))) : b_i;
          hi_d    = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        hi_d = hi_nx;
        lo_d = lo_nx;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          p_d     = sgn_q ? PW'(neg2w(64'({hi_nx, lo_nx}))) : {hi_nx, lo_nx};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_mag_q <= '0;
      sgn_q   <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_mag_q <= a_mag_d;
      sgn_q   <= sgn_d;
      p_q     <= p_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q == RUN);
  assign out_valid_o = (state_q == DONE);
  assign p_o         = p_q;

endmodule
